fifo_sram_rd_stage: RTL and testbench

- Read-side controller of the async FIFO, clocked in the read domain, directly downstream of the 1rw1r SRAM macro's read-only port 1.
- Compares its own read pointer against the already-synchronised write pointer and issues SRAM reads.
- Captures the SRAM output, which is launched on the falling edge, into a 2-entry skid buffer.
- Presents the data as a valid/ready stream and publishes a Gray-coded read pointer for synchronisation into the write domain.

---
 rtl/fifo_sram_rd_stage.sv | 127 ++++++++++++
 tb/tb_fifo_sram_rd_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_rd_stage.sv
// Async FIFO read-side stage: issues reads to SRAM port 1, captures data into a 2-entry skid buffer,
// and publishes binary/Gray read pointers. Define RD_LEVEL_EN to add the registered rd_level output.
module fifo_sram_rd_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wptr_bin,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   rptr_bin,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty
`ifdef RD_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] rd_level
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         iptr_q, iptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         rgray_q, rgray_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  head_q, head_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic       pop;
    logic       issue;
    logic [2:0] occ;

    always_comb begin
        iptr_d     = iptr_q;
        rptr_d     = rptr_q;
        addr_d     = addr_q;
        head_d     = head_q;
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        buf_cnt_d  = buf_cnt_q;

        pop   = (buf_cnt_q != 2'd0) && out_ready;
        occ   = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
        // Only issue if the word is guaranteed a buffer slot when it lands next cycle.
        issue = (iptr_q != wptr_bin) && ((occ <= 3'd1) || (pop && (occ <= 3'd2)));

        if (issue) begin
            iptr_d = iptr_q + 1'b1;
            addr_d = iptr_q[ADDR_WIDTH-1:0];
        end
        inflight_d = issue;

        // Read pointer commits only once the word has actually been captured.
        if (inflight_q) begin
            buf_d[head_q ^ buf_cnt_q[0]] = sram_dout1;
            rptr_d = rptr_q + 1'b1;
        end
        rgray_d = rptr_d ^ (rptr_d >> 1);

        buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        if (pop) begin
            head_d = ~head_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iptr_q     <= '0;
            rptr_q     <= '0;
            rgray_q    <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            head_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            iptr_q     <= iptr_d;
            rptr_q     <= rptr_d;
            rgray_q    <= rgray_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    assign sram_csb1  = ~issue;
    assign sram_addr1 = issue ? iptr_q[ADDR_WIDTH-1:0] : addr_q;
    assign out_valid  = (buf_cnt_q != 2'd0);
    assign out_data   = buf_q[head_q];
    assign rptr_bin   = rptr_q;
    assign rptr_gray  = rgray_q;
    assign empty      = (iptr_q == wptr_bin);

`ifdef RD_LEVEL_EN
    logic [PW:0]   level_q, level_d;
    logic [PW-1:0] unread;

    // Words still in the SRAM plus words already sitting in the skid buffer.
    always_comb begin
        unread  = wptr_bin - rptr_q;
        level_d = {1'b0, unread} + {{(PW-1){1'b0}}, buf_cnt_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rd_level = level_q;
`endif

endmodule

// File: tb/tb_fifo_sram_rd_stage.sv
// Scoreboard bench for fifo_sram_rd_stage with a falling-edge SRAM port model and a queue reference model.
module tb_fifo_sram_rd_stage;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] wptr_bin;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_gray;
    logic          empty;
`ifdef RD_LEVEL_EN
    logic [PW:0]   rd_level;
`endif

    always #5 clk = ~clk;

    fifo_sram_rd_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .wptr_bin(wptr_bin),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rptr_bin(rptr_bin), .rptr_gray(rptr_gray), .empty(empty)
`ifdef RD_LEVEL_EN
        , .rd_level(rd_level)
`endif
    );

    // SRAM port 1 model: registers csb/addr at posedge, drives dout at the following negedge.
    logic [DW-1:0] mem [DEPTH];
    logic          pre_rd = 1'b0, rd_q = 1'b0;
    logic [AW-1:0] pre_a = '0, ra_q = '0;
    logic [31:0]   n_issued = 0;
    logic [AW-1:0] iss_log [1024];

    always @(negedge clk) begin
        if (rd_q) sram_dout1 <= mem[ra_q];
        pre_rd <= ~sram_csb1;
        pre_a  <= sram_addr1;
    end

    always @(posedge clk) begin
        rd_q <= pre_rd;
        ra_q <= pre_a;
        if (pre_rd) begin
            iss_log[n_issued % 1024] <= pre_a;
            n_issued <= n_issued + 1;
        end
    end

    // Reference model: words in the order they were written.
    logic [DW-1:0] expq [$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_pop = 0;
    int            cyc = 0;
    int            pop_cyc [4096];
    logic [PW-1:0] wp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and checks hold stability under backpressure.
    initial begin
        logic          hold_v;
        logic [DW-1:0] hold_d;
        logic [DW-1:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                chk("buf_cnt_le2", 64'(dut.buf_cnt_q <= 2'd2), 64'd1);
                if (hold_v) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'(out_data), 64'(hold_d));
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected no word", out_data);
                    end else begin
                        e = expq.pop_front();
                        chk("data", 64'(out_data), 64'(e));
                    end
                    pop_cyc[n_pop % 4096] = cyc;
                    n_pop++;
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wp[AW-1:0]] = d;
        expq.push_back(d);
        wp = wp + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        wp = '0;
        wptr_bin = '0;
        expq.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(expq.size()), 64'd0);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n;
        n = 0;
        while (n_pop < target && n < budget) begin
            tick();
            n++;
        end
        chk("pop_count", 64'(n_pop >= target), 64'd1);
    endtask

    initial begin
        int            base, pbase, k;
        logic [PW-1:0] used;

        // Reset state and idle
        rst = 1'b1;
        out_ready = 1'b0;
        wptr_bin = '0;
        wp = '0;
        tick();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_csb", 64'(sram_csb1), 64'd1);
        chk("rst_addr", 64'(sram_addr1), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_rptr", 64'(rptr_bin), 64'd0);
        chk("rst_gray", 64'(rptr_gray), 64'd0);
        tick();
        rst = 1'b0;
        base = n_issued;
        repeat (10) tick();
        chk("idle_issues", 64'(n_issued - base), 64'd0);
        chk("idle_csb", 64'(sram_csb1), 64'd1);

        // Single word latency
        write_word(32'hDEADBEEF);
        wptr_bin = wp;
        out_ready = 1'b1;
        #1;
        chk("t2_csb", 64'(sram_csb1), 64'd0);
        chk("t2_addr", 64'(sram_addr1), 64'd0);
        tick();
        chk("t2_csb_after", 64'(sram_csb1), 64'd1);
        chk("t2_valid_early", 64'(out_valid), 64'd0);
        tick();
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_data", 64'(out_data), 64'hDEADBEEF);
        chk("t2_rptr", 64'(rptr_bin), 64'd1);
        chk("t2_gray", 64'(rptr_gray), 64'd1);
        tick();
        chk("t2_valid_end", 64'(out_valid), 64'd0);
        chk("t2_empty", 64'(empty), 64'd1);

        // Eight words at full rate
        do_reset();
        for (int i = 0; i < 8; i++) write_word(DW'(i));
        pbase = n_pop;
        out_ready = 1'b1;
        wptr_bin = wp;
        wait_pops(pbase + 8, 40);
        chk("t3_span", 64'(pop_cyc[(pbase + 7) % 4096] - pop_cyc[pbase % 4096]), 64'd7);
        tick();
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_rptr", 64'(rptr_bin), 64'd8);
        chk("t3_gray", 64'(rptr_gray), 64'hC);

        // Backpressure: only two reads may be outstanding
        do_reset();
        for (int i = 0; i < 8; i++) write_word(DW'(i));
        base = n_issued;
        pbase = n_pop;
        wptr_bin = wp;
        repeat (10) tick();
        chk("t4_issues", 64'(n_issued - base), 64'd2);
        chk("t4_csb", 64'(sram_csb1), 64'd1);
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_data", 64'(out_data), 64'd0);
        drain(60);
        chk("t4_pops", 64'(n_pop - pbase), 64'd8);

        // Pointer wrap through 255 -> 0 with MSB toggle
        do_reset();
        while (wp < 255) begin
            k = $urandom_range(1, 8);
            for (int i = 0; i < k && wp < 255; i++) write_word($urandom);
            wptr_bin = wp;
            out_ready = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 3)) tick();
        end
        drain(600);
        chk("t5_rptr255", 64'(rptr_bin), 64'd255);
        chk("t5_empty255", 64'(empty), 64'd1);
        for (int i = 0; i < 3; i++) write_word($urandom);
        base = n_issued;
        wptr_bin = wp;
        drain(40);
        chk("t5_issues", 64'(n_issued - base), 64'd3);
        chk("t5_addr0", 64'(iss_log[base % 1024]), 64'd255);
        chk("t5_addr1", 64'(iss_log[(base + 1) % 1024]), 64'd0);
        chk("t5_addr2", 64'(iss_log[(base + 2) % 1024]), 64'd1);
        chk("t5_rptr", 64'(rptr_bin), 64'h102);
        chk("t5_msb", 64'(rptr_bin[AW]), 64'd1);
        chk("t5_empty", 64'(empty), 64'd1);

        // Random traffic up to a full FIFO
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            out_ready = (c % 300 < 200) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                used = wp - rptr_bin;
                k = $urandom_range(0, 4);
                for (int i = 0; i < k && int'(used) + i < DEPTH; i++) write_word($urandom);
                wptr_bin = wp;
            end
            tick();
        end
        drain(800);
        chk("t6_rptr", 64'(rptr_bin), 64'(wp));
        chk("t6_gray", 64'(rptr_gray), 64'(wp ^ (wp >> 1)));

        // Reset in the middle of a stream
        do_reset();
        for (int i = 0; i < 8; i++) write_word(DW'(100 + i));
        pbase = n_pop;
        out_ready = 1'b1;
        wptr_bin = wp;
        wait_pops(pbase + 3, 20);
        rst = 1'b1;
        wp = '0;
        wptr_bin = '0;
        expq.delete();
        tick();
        chk("t7_valid", 64'(out_valid), 64'd0);
        chk("t7_csb", 64'(sram_csb1), 64'd1);
        chk("t7_rptr", 64'(rptr_bin), 64'd0);
        chk("t7_empty", 64'(empty), 64'd1);
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
`ifdef RD_LEVEL_EN
        chk("lvl_reset", 64'(rd_level), 64'd0);
        for (int i = 0; i < 8; i++) write_word($urandom);
        wptr_bin = wp;
        tick();
        tick();
        chk("lvl_8", 64'(rd_level), 64'd8);
        repeat (4) tick();
        chk("lvl_8_held", 64'(rd_level), 64'd8);
        drain(40);
        tick();
        chk("lvl_0", 64'(rd_level), 64'd0);
`endif
        for (int i = 0; i < 5; i++) write_word($urandom);
        wptr_bin = wp;
        drain(40);
        chk("t7_rptr_end", 64'(rptr_bin), 64'(wp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
